// File: rtl/csr_issue.sv
// CSR issue stage: decodes SYSTEM-class instructions from decode into the CSR unit's
// control set, with a one-entry skid buffer and a wrong-path flush after ecall/mret.
module csr_issue #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [63:0] in_pc,
  input  logic [63:0] in_rs1,
  input  logic        stall,
  output logic        en,
  output logic        ecall,
  output logic        mret,
  output logic        csrr,
  output logic        illegal,
  output logic [2:0]  func3,
  output logic [11:0] csr_a,
  output logic [4:0]  rd_a,
  output logic        rd_w,
  output logic [63:0] rs1_reg,
  output logic        rs1_sel,
  output logic [63:0] pc
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES);

  typedef struct packed {
    logic        ecall;
    logic        mret;
    logic        csrr;
    logic        illegal;
    logic        imm;
    logic [2:0]  func3;
    logic [11:0] csr_a;
    logic [4:0]  rd_a;
    logic        rd_w;
    logic [4:0]  rs1_a;
    logic [63:0] rs1_reg;
    logic        rs1_sel;
    logic [63:0] pc;
  } slot_t;

  function automatic slot_t decode(input logic [31:0] inst, input logic [63:0] pc_i,
                                   input logic [63:0] rs1_i);
    slot_t s;
    s       = '0;
    s.csr_a = inst[31:20];
    s.rd_a  = inst[11:7];
    s.rs1_a = inst[19:15];
    s.pc    = pc_i;
    if (inst[6:0] != 7'h73) s.illegal = 1'b1;
    else begin
      case (inst[14:12])
        3'd0: begin
          if (inst[31:20] == 12'h000)      s.ecall   = 1'b1;
          else if (inst[31:20] == 12'h302) s.mret    = 1'b1;
          else                             s.illegal = 1'b1;
        end
        3'd1, 3'd2, 3'd3: begin
          s.csrr    = 1'b1;
          s.func3   = inst[14:12];
          s.rs1_reg = rs1_i;
        end
        3'd5, 3'd6, 3'd7: begin
          s.csrr    = 1'b1;
          s.imm     = 1'b1;
          s.func3   = {1'b0, inst[13:12]};
          s.rs1_reg = {59'b0, inst[19:15]};
        end
        default: s.illegal = 1'b1;
      endcase
    end
    s.rd_w = s.csrr && (s.rd_a != 5'd0);
    return s;
  endfunction

  // Forward only from the op that issues in the very cycle its successor enters OR.
  function automatic logic fwd(input slot_t nxt, input slot_t prev, input logic issued);
    return nxt.csrr && !nxt.imm && (nxt.rs1_a != 5'd0) &&
           issued && prev.rd_w && (prev.rd_a == nxt.rs1_a);
  endfunction

  logic [0:0] state;
  logic [3:0] cnt;
  logic       ov, sv;
  slot_t      or_q, sk_q, in_dec, in_ld, sk_ld;
  logic       acc, redirect;

  assign in_ready = !sv;
  assign en       = ov && !stall;
  assign acc      = in_valid && in_ready;
  assign redirect = en && (or_q.ecall || or_q.mret);
  assign in_dec   = decode(in_inst, in_pc, in_rs1);

  always_comb begin
    in_ld         = in_dec;
    in_ld.rs1_sel = fwd(in_dec, or_q, en);
    sk_ld         = sk_q;
    sk_ld.rs1_sel = fwd(sk_q, or_q, en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
      ov    <= 1'b0;
      sv    <= 1'b0;
      or_q  <= '0;
      sk_q  <= '0;
    end else if (state == FLUSH) begin
      cnt <= cnt - 4'd1;
      if (cnt <= 4'd1) state <= RUN;
    end else if (redirect) begin
      state <= FLUSH;
      cnt   <= FLUSH_CNT;
      ov    <= 1'b0;
      sv    <= 1'b0;
    end else if (!ov || en) begin
      if (sv) begin
        or_q <= sk_ld;
        ov   <= 1'b1;
        sv   <= acc;
        if (acc) sk_q <= in_dec;
      end else if (acc) begin
        or_q <= in_ld;
        ov   <= 1'b1;
      end else begin
        ov <= 1'b0;
      end
    end else if (acc) begin
      sk_q <= in_dec;
      sv   <= 1'b1;
    end
  end

  assign ecall   = or_q.ecall;
  assign mret    = or_q.mret;
  assign csrr    = or_q.csrr;
  assign illegal = en && or_q.illegal;
  assign func3   = or_q.func3;
  assign csr_a   = or_q.csr_a;
  assign rd_a    = or_q.rd_a;
  assign rd_w    = or_q.rd_w;
  assign rs1_reg = or_q.rs1_reg;
  assign rs1_sel = or_q.rs1_sel;
  assign pc      = or_q.pc;

endmodule
